// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
// Imported by countdown_timer and countdown_timer_flopr_en.
package countdown_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_flopr_en.sv
// Enabled register with synchronous active-high clear.
// Ports: clk, i_sclr (clear), i_en (load enable), i_d (data), o_q (state).
module countdown_timer_flopr_en
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (i_en) begin
            q_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable one-shot down-counter with start/stop, counting on i_en ticks.
// Ports: clk, i_sclr, i_load/i_load_val, i_start, i_stop, i_en -> o_cnt,
// o_busy (RUN or PAUSE), o_done (one-cycle completion pulse).
// Option: COUNTDOWN_TIMER_AUTORELOAD_EN reloads the last loaded value on the
// terminal tick and keeps running, giving a periodic o_done strobe.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_en;
    logic             cnt_nz;
    logic             cnt_last;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    always_comb begin
        reload_d = reload_q;
        if (i_load) begin
            reload_d = i_load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign cnt_nz   = (cnt_q != '0);
    assign cnt_last = (cnt_q == CNT_ONE);

    // i_stop outranks i_start, so asserting both never arms or resumes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_en  = 1'b0;
        done_d  = 1'b0;
        if (i_load) begin
            cnt_d   = i_load_val;
            cnt_en  = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!i_stop && i_start && cnt_nz) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        state_d = ST_PAUSE;
                    end else if (i_en && cnt_last) begin
                        cnt_en = 1'b1;
                        done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        if (reload_q != '0) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
`else
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end else if (i_en && cnt_nz) begin
                        cnt_en = 1'b1;
                        cnt_d  = cnt_q - CNT_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (!i_stop && i_start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Busy is registered from the next state so it falls with o_done.
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    countdown_timer_flopr_en #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .i_sclr (i_sclr),
        .i_en   (cnt_en),
        .i_d    (cnt_d),
        .o_q    (cnt_q)
    );

    assign o_cnt  = cnt_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (WIDTH=4).
// Honours COUNTDOWN_TIMER_AUTORELOAD_EN for the reload scenario.
module tb_countdown_timer;

    logic       clk;
    logic       i_sclr;
    logic       i_load;
    logic [3:0] i_load_val;
    logic       i_start;
    logic       i_stop;
    logic       i_en;
    logic [3:0] o_cnt;
    logic       o_busy;
    logic       o_done;

    typedef struct {
        logic [3:0] c;
        logic       b;
        logic       d;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    countdown_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_en       (i_en),
        .o_cnt      (o_cnt),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic drv(input logic sclr, input logic load,
                       input logic [3:0] lv, input logic start,
                       input logic stop, input logic en,
                       input logic [3:0] ec, input logic eb,
                       input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        i_sclr     = sclr;
        i_load     = load;
        i_load_val = lv;
        i_start    = start;
        i_stop     = stop;
        i_en       = en;
        e.c   = ec;
        e.b   = eb;
        e.d   = ed;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if ({o_cnt, o_busy, o_done} === {e.c, e.b, e.d}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                         e.tag, o_cnt, o_busy, o_done, e.c, e.b, e.d);
            end
        end
    end

    initial begin
        n_pass     = 0;
        n_total    = 0;
        i_sclr     = 1'b0;
        i_load     = 1'b0;
        i_load_val = 4'd0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_en       = 1'b0;

        // Reset with garbage on every input, then a start with count 0.
        drv(1, 1, 4'hA, 1, 1, 1, 4'd0, 0, 0, "rst0");
        drv(1, 1, 4'h7, 1, 0, 1, 4'd0, 0, 0, "rst1");
        drv(0, 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "start_zero");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "idle_en");

        // One-shot of 5 with i_en held; start in RUN is a no-op.
        drv(0, 1, 4'd5, 0, 0, 0, 4'd5, 0, 0, "os_load");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd5, 1, 0, "os_start");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd4, 1, 0, "os_run_start");
        for (int k = 3; k >= 1; k--) begin
            drv(0, 0, 4'd0, 0, 0, 1, 4'(k), 1, 0, "os_tick");
        end
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 1, "os_done");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "os_after");

        // Pause and resume.
        drv(0, 1, 4'd6, 0, 0, 0, 4'd6, 0, 0, "pr_load");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd6, 1, 0, "pr_start");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd5, 1, 0, "pr_t1");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd4, 1, 0, "pr_t2");
        drv(0, 0, 4'd0, 0, 1, 1, 4'd4, 1, 0, "pr_stop");
        for (int k = 0; k < 10; k++) begin
            drv(0, 0, 4'd0, 0, 0, 1, 4'd4, 1, 0, "pr_hold");
        end
        drv(0, 0, 4'd0, 1, 0, 1, 4'd4, 1, 0, "pr_resume");
        for (int k = 3; k >= 1; k--) begin
            drv(0, 0, 4'd0, 0, 0, 1, 4'(k), 1, 0, "pr_tick");
        end
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 1, "pr_done");

        // Load outranks stop and tick while running.
        drv(0, 1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "pri_load");
        drv(0, 0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "pri_start");
        drv(0, 1, 4'd9, 0, 1, 1, 4'd9, 0, 0, "pri_cancel");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd9, 0, 0, "pri_idle");

        // All-ones load counts the full range.
        drv(0, 1, 4'd15, 0, 0, 0, 4'd15, 0, 0, "max_load");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd15, 1, 0, "max_start");
        for (int k = 14; k >= 1; k--) begin
            drv(0, 0, 4'd0, 0, 0, 1, 4'(k), 1, 0, "max_tick");
        end
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 1, "max_done");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "max_after");

        // Sparse ticks: one in three cycles.
        drv(0, 1, 4'd4, 0, 0, 0, 4'd4, 0, 0, "sp_load");
        drv(0, 0, 4'd0, 1, 0, 0, 4'd4, 1, 0, "sp_start");
        for (int k = 3; k >= 1; k--) begin
            drv(0, 0, 4'd0, 0, 0, 0, 4'(k + 1), 1, 0, "sp_gap");
            drv(0, 0, 4'd0, 0, 0, 0, 4'(k + 1), 1, 0, "sp_gap");
            drv(0, 0, 4'd0, 0, 0, 1, 4'(k), 1, 0, "sp_tick");
        end
        drv(0, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "sp_gap");
        drv(0, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "sp_gap");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 1, "sp_done");

        // Reset on the terminal tick suppresses o_done.
        drv(0, 1, 4'd2, 0, 0, 0, 4'd2, 0, 0, "rt_load");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd2, 1, 0, "rt_start");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd1, 1, 0, "rt_tick");
        drv(1, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "rt_reset");
        drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "rt_after");

        // Load 3, run 10 ticks: periodic with reload, one-shot without.
        drv(0, 1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "ar_load");
        drv(0, 0, 4'd0, 1, 0, 1, 4'd3, 1, 0, "ar_start");
        for (int i = 1; i <= 10; i++) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            drv(0, 0, 4'd0, 0, 0, 1,
                (i % 3 == 0) ? 4'd3 : 4'(3 - (i % 3)),
                1, (i % 3 == 0), "ar_tick");
`else
            if (i < 3) begin
                drv(0, 0, 4'd0, 0, 0, 1, 4'(3 - i), 1, 0, "ar_tick");
            end else if (i == 3) begin
                drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 1, "ar_done");
            end else begin
                drv(0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "ar_idle");
            end
`endif
        end
        drv(0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0, "ar_stopload");

        @(negedge clk);
        i_load = 1'b0;
        i_en   = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
